// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty fetch path: FSM state encoding and
// default geometry of the instruction store.
package bitty_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/instr_mem.sv
// Instruction store: one write port and one registered read port.
// A read and a write to the same address on the same edge return the old word.
module instr_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write and read share the edge; non-blocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks instruction memory from address 0, presents
// each word to the control unit until it retires it, follows branches, and
// stops on the halt word. The memory read is launched on the edge that enters
// FETCH, so the word is available throughout the single FETCH cycle.
module fetch_unit
  import bitty_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              done,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W-1:0] rd_data;
  logic              rd_en;

  // Read only when the next cycle is a FETCH; address is the PC it will fetch.
  assign rd_en = (state_next == FETCH);

  instr_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (rd_en),
    .raddr (pc_next),
    .rdata (rd_data)
  );

  // State register; reset forces IDLE immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and next PC; done/branch only matter in WAIT, start only in IDLE/HALT.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          pc_next    = '0;
        end
      end
      FETCH: begin
        state_next = (rd_data == HALT_WORD) ? HALT : WAIT;
      end
      WAIT: begin
        if (done) begin
          state_next = FETCH;
          pc_next    = branch_en ? branch_addr : pc + ADDR_W'(1);
        end
      end
      HALT: begin
        if (start) begin
          state_next = FETCH;
          pc_next    = '0;
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = '0;
      end
    endcase
  end

  // PC, presented instruction and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= '0;
      inst       <= '0;
      inst_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      pc <= pc_next;
      if (state == FETCH) begin
        if (rd_data != HALT_WORD) begin
          inst       <= rd_data;
          inst_valid <= 1'b1;
        end else begin
          halted     <= 1'b1;
          inst_valid <= 1'b0;
        end
      end
      if (state == WAIT && done) inst_valid <= 1'b0;
      if (state == HALT && start) halted <= 1'b0;
    end
  end

endmodule
